// File: rtl/pr_pkg.sv
// Shared definitions for the D/E/H/L register-file sequencer:
// request op codes, register indices and the issue FSM state type.
package pr_pkg;

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_EX    = 2'b01;
   localparam logic [1:0] OP_EXX   = 2'b10;
   localparam logic [1:0] OP_RSVD  = 2'b11;

   localparam logic [1:0] REG_D = 2'd0;
   localparam logic [1:0] REG_E = 2'd1;
   localparam logic [1:0] REG_H = 2'd2;
   localparam logic [1:0] REG_L = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      GUARD = 2'd2
   } pr_state_t;

   // One-hot write strobe for a register index, bit 0 = D ... bit 3 = L
   function automatic logic [3:0] write_onehot(input logic [1:0] dst);
      write_onehot = 4'b0001 << dst;
   endfunction

endpackage

// File: rtl/pr_req_fifo.sv
// Small synchronous request FIFO with full/empty flags and an occupancy
// count. A push while full is taken only when a pop frees the slot in
// the same cycle.
module pr_req_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wr_data,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rd_data = mem[rd_ptr];

   // Storage array; contents need no reset since count guards every read
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pr_sequencer.sv
// Register-file update sequencer: buffers decode requests and issues them
// as registered, mutually exclusive select strobes for the D/E/H/L slices,
// with a settle cycle after each exchange and a tracked active bank.
module pr_sequencer
   import pr_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic       Clk,
   input  logic       notReset,
   input  logic       ReqValid,
   output logic       ReqReady,
   input  logic [1:0] ReqOp,
   input  logic [1:0] ReqDst,
   output logic [3:0] PR_Write,
   output logic       PR_Ex,
   output logic       notPR_Ex,
   output logic       PR_Exx,
   output logic       notPR_Exx,
   output logic       ShadowLoad,
   output logic       BankSel,
   output logic       Busy,
   output logic       OpErr
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   pr_state_t     state;
   pr_state_t     state_d;
   logic [1:0]    cur_op;
   logic [1:0]    cur_op_d;
   logic [3:0]    pr_write_q;
   logic [3:0]    pr_write_d;
   logic          pr_ex_q;
   logic          pr_ex_d;
   logic          pr_exx_q;
   logic          pr_exx_d;
   logic          bank_sel_q;
   logic          bank_sel_d;
   logic          op_err_q;
   logic          op_err_d;
   logic          busy_q;
   logic          busy_d;
   logic          push;
   logic          pop;
   logic          issue_done;
   logic          can_issue;
   logic          fifo_full;
   logic          fifo_empty;
   logic [3:0]    fifo_rd;
   logic [1:0]    head_op;
   logic [1:0]    head_dst;
   logic [CW-1:0] fifo_count;
   logic [CW-1:0] count_d;

   assign ReqReady   = ~fifo_full;
   assign push       = ReqValid & ~fifo_full;
   assign head_op    = fifo_rd[3:2];
   assign head_dst   = fifo_rd[1:0];

   assign PR_Write   = pr_write_q;
   assign PR_Ex      = pr_ex_q;
   assign notPR_Ex   = ~pr_ex_q;
   assign PR_Exx     = pr_exx_q;
   assign notPR_Exx  = ~pr_exx_q;
   assign ShadowLoad = pr_exx_q;
   assign BankSel    = bank_sel_q;
   assign Busy       = busy_q;
   assign OpErr      = op_err_q;

   pr_req_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (4)
   ) u_fifo (
      .clk     (Clk),
      .rst_n   (notReset),
      .push    (push),
      .pop     (pop),
      .wr_data ({ReqOp, ReqDst}),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Next state and next strobe values; a pop loads the strobes for the
   // cycle that follows, so the strobes themselves are pure registers
   always_comb begin
      issue_done = (state == ISSUE) && ((cur_op == OP_WRITE) || (cur_op == OP_RSVD));
      can_issue  = (state == IDLE) || (state == GUARD) || issue_done;
      pop        = can_issue && !fifo_empty;
      state_d    = IDLE;
      cur_op_d   = cur_op;
      pr_write_d = 4'b0000;
      pr_ex_d    = 1'b0;
      pr_exx_d   = 1'b0;
      bank_sel_d = bank_sel_q;
      op_err_d   = op_err_q | (push && (ReqOp == OP_RSVD));
      count_d    = fifo_count;

      if ((state == ISSUE) && (cur_op == OP_EXX)) begin
         bank_sel_d = ~bank_sel_q;
      end

      if (pop) begin
         state_d  = ISSUE;
         cur_op_d = head_op;
         case (head_op)
            OP_WRITE: pr_write_d = write_onehot(head_dst);
            OP_EX:    pr_ex_d    = 1'b1;
            OP_EXX:   pr_exx_d   = 1'b1;
            default:  pr_write_d = 4'b0000;
         endcase
      end else if ((state == ISSUE) && !issue_done) begin
         state_d = GUARD;
      end

      case ({push, pop})
         2'b10:   count_d = fifo_count + CW'(1);
         2'b01:   count_d = fifo_count - CW'(1);
         default: count_d = fifo_count;
      endcase

      busy_d = (count_d != '0) || (state_d != IDLE);
   end

   // State, strobe, bank and error registers, all cleared asynchronously
   always_ff @(posedge Clk or negedge notReset) begin
      if (!notReset) begin
         state      <= IDLE;
         cur_op     <= OP_WRITE;
         pr_write_q <= 4'b0000;
         pr_ex_q    <= 1'b0;
         pr_exx_q   <= 1'b0;
         bank_sel_q <= 1'b0;
         op_err_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state      <= state_d;
         cur_op     <= cur_op_d;
         pr_write_q <= pr_write_d;
         pr_ex_q    <= pr_ex_d;
         pr_exx_q   <= pr_exx_d;
         bank_sel_q <= bank_sel_d;
         op_err_q   <= op_err_d;
         busy_q     <= busy_d;
      end
   end

endmodule

// File: tb/tb_pr_sequencer.sv
// Directed bench for pr_sequencer: a vector table for the single-step
// behaviour plus hand-written backpressure and mid-issue reset sequences.
module tb_pr_sequencer;

   logic       Clk;
   logic       notReset;
   logic       ReqValid;
   logic       ReqReady;
   logic [1:0] ReqOp;
   logic [1:0] ReqDst;
   logic [3:0] PR_Write;
   logic       PR_Ex;
   logic       notPR_Ex;
   logic       PR_Exx;
   logic       notPR_Exx;
   logic       ShadowLoad;
   logic       BankSel;
   logic       Busy;
   logic       OpErr;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       valid;
      logic [1:0] op;
      logic [1:0] dst;
      logic [3:0] write;
      logic       ex;
      logic       exx;
      logic       bank;
      logic       busy;
      logic       ready;
      logic       err;
   } vec_t;

   vec_t vecs[21];

   pr_sequencer #(.FIFO_DEPTH(2)) dut (
      .Clk        (Clk),
      .notReset   (notReset),
      .ReqValid   (ReqValid),
      .ReqReady   (ReqReady),
      .ReqOp      (ReqOp),
      .ReqDst     (ReqDst),
      .PR_Write   (PR_Write),
      .PR_Ex      (PR_Ex),
      .notPR_Ex   (notPR_Ex),
      .PR_Exx     (PR_Exx),
      .notPR_Exx  (notPR_Exx),
      .ShadowLoad (ShadowLoad),
      .BankSel    (BankSel),
      .Busy       (Busy),
      .OpErr      (OpErr)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive one request (or none) and advance to 1 time unit after the edge
   task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [1:0] dst);
      ReqValid = v;
      ReqOp    = op;
      ReqDst   = dst;
      @(posedge Clk);
      #1;
   endtask

   task automatic putVec(input int i, input logic v, input logic [1:0] op, input logic [1:0] dst,
                         input logic [3:0] w, input logic ex, input logic exx, input logic bank,
                         input logic busy, input logic ready, input logic err);
      vecs[i] = '{v, op, dst, w, ex, exx, bank, busy, ready, err};
   endtask

   task automatic checkRow(input int i);
      checkOutput($sformatf("v%0d.PR_Write", i), {4'b0, PR_Write}, {4'b0, vecs[i].write});
      checkOutput($sformatf("v%0d.PR_Ex", i), {6'b0, notPR_Ex, PR_Ex}, {6'b0, ~vecs[i].ex, vecs[i].ex});
      checkOutput($sformatf("v%0d.PR_Exx", i), {5'b0, ShadowLoad, notPR_Exx, PR_Exx},
                  {5'b0, vecs[i].exx, ~vecs[i].exx, vecs[i].exx});
      checkOutput($sformatf("v%0d.status", i), {4'b0, BankSel, Busy, ReqReady, OpErr},
                  {4'b0, vecs[i].bank, vecs[i].busy, vecs[i].ready, vecs[i].err});
   endtask

   initial begin
      int accepted;
      int ex_seen;
      int guard_bad;
      int saw_full;
      logic prev_ex;

      // valid op dst | write ex exx bank busy ready err
      putVec( 0, 1, 2'b00, 2'd0, 4'b0000, 0, 0, 0, 1, 1, 0);
      putVec( 1, 1, 2'b00, 2'd1, 4'b0001, 0, 0, 0, 1, 1, 0);
      putVec( 2, 1, 2'b00, 2'd2, 4'b0010, 0, 0, 0, 1, 1, 0);
      putVec( 3, 1, 2'b00, 2'd3, 4'b0100, 0, 0, 0, 1, 1, 0);
      putVec( 4, 0, 2'b00, 2'd0, 4'b1000, 0, 0, 0, 1, 1, 0);
      putVec( 5, 0, 2'b00, 2'd0, 4'b0000, 0, 0, 0, 0, 1, 0);
      putVec( 6, 1, 2'b01, 2'd0, 4'b0000, 0, 0, 0, 1, 1, 0);
      putVec( 7, 1, 2'b00, 2'd3, 4'b0000, 1, 0, 0, 1, 1, 0);
      putVec( 8, 0, 2'b00, 2'd0, 4'b0000, 0, 0, 0, 1, 1, 0);
      putVec( 9, 0, 2'b00, 2'd0, 4'b1000, 0, 0, 0, 1, 1, 0);
      putVec(10, 0, 2'b00, 2'd0, 4'b0000, 0, 0, 0, 0, 1, 0);
      putVec(11, 1, 2'b10, 2'd0, 4'b0000, 0, 0, 0, 1, 1, 0);
      putVec(12, 1, 2'b10, 2'd0, 4'b0000, 0, 1, 0, 1, 1, 0);
      putVec(13, 0, 2'b00, 2'd0, 4'b0000, 0, 0, 1, 1, 1, 0);
      putVec(14, 0, 2'b00, 2'd0, 4'b0000, 0, 1, 1, 1, 1, 0);
      putVec(15, 0, 2'b00, 2'd0, 4'b0000, 0, 0, 0, 1, 1, 0);
      putVec(16, 0, 2'b00, 2'd0, 4'b0000, 0, 0, 0, 0, 1, 0);
      putVec(17, 1, 2'b11, 2'd0, 4'b0000, 0, 0, 0, 1, 1, 1);
      putVec(18, 1, 2'b00, 2'd0, 4'b0000, 0, 0, 0, 1, 1, 1);
      putVec(19, 0, 2'b00, 2'd0, 4'b0001, 0, 0, 0, 1, 1, 1);
      putVec(20, 0, 2'b00, 2'd0, 4'b0000, 0, 0, 0, 0, 1, 1);

      // Reset and check the post-release state
      notReset = 1'b0;
      ReqValid = 1'b0;
      ReqOp    = 2'b00;
      ReqDst   = 2'd0;
      repeat (3) @(posedge Clk);
      #1;
      checkOutput("in_reset.complements", {6'b0, notPR_Exx, notPR_Ex}, 8'h03);
      notReset = 1'b1;
      @(posedge Clk);
      #1;
      checkOutput("reset.PR_Write", {4'b0, PR_Write}, 8'h00);
      checkOutput("reset.strobes", {3'b0, PR_Ex, notPR_Ex, PR_Exx, notPR_Exx, ShadowLoad}, 8'b0000_1010);
      checkOutput("reset.status", {4'b0, BankSel, Busy, ReqReady, OpErr}, 8'b0000_0010);

      // Table: writes, EX then WRITE L, EXX twice, reserved then WRITE D
      for (int i = 0; i < 21; i++) begin
         applyStimulus(vecs[i].valid, vecs[i].op, vecs[i].dst);
         checkRow(i);
      end

      // Backpressure: hold ReqValid for four EX requests
      accepted  = 0;
      ex_seen   = 0;
      guard_bad = 0;
      saw_full  = 0;
      prev_ex   = 1'b0;
      for (int cyc = 0; cyc < 16; cyc++) begin
         ReqValid = (accepted < 4);
         ReqOp    = 2'b01;
         ReqDst   = 2'd0;
         if (ReqValid && ReqReady) accepted++;
         if (!ReqReady) saw_full = 1;
         @(posedge Clk);
         #1;
         if (prev_ex && (PR_Ex || PR_Exx || (PR_Write != 4'b0000))) guard_bad++;
         if (PR_Ex) ex_seen++;
         prev_ex = PR_Ex;
      end
      checkOutput("bp.accepted", 8'(accepted), 8'd4);
      checkOutput("bp.ex_issued", 8'(ex_seen), 8'd4);
      checkOutput("bp.ready_dropped", 8'(saw_full), 8'd1);
      checkOutput("bp.guard_after_ex", 8'(guard_bad), 8'd0);
      checkOutput("bp.idle_after", {6'b0, Busy, ReqReady}, 8'b01);
      checkOutput("bp.operr_sticky", {7'b0, OpErr}, 8'd1);

      // Mid-issue reset: first move to the alternate bank
      applyStimulus(1'b1, 2'b10, 2'd0);
      applyStimulus(1'b0, 2'b00, 2'd0);
      applyStimulus(1'b0, 2'b00, 2'd0);
      applyStimulus(1'b0, 2'b00, 2'd0);
      checkOutput("mr.bank_before", {7'b0, BankSel}, 8'd1);
      applyStimulus(1'b1, 2'b10, 2'd0);
      applyStimulus(1'b1, 2'b00, 2'd0);
      checkOutput("mr.exx_issuing", {6'b0, ShadowLoad, PR_Exx}, 8'b11);
      ReqValid = 1'b0;
      #2;
      notReset = 1'b0;
      #1;
      checkOutput("mr.strobes_drop", {2'b0, PR_Write, PR_Exx, PR_Ex}, 8'h00);
      checkOutput("mr.complements", {5'b0, ShadowLoad, notPR_Exx, notPR_Ex}, 8'b011);
      checkOutput("mr.status", {4'b0, BankSel, Busy, ReqReady, OpErr}, 8'b0000_0010);
      @(posedge Clk);
      #1;
      notReset = 1'b1;
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b0, 2'b00, 2'd0);
         checkOutput($sformatf("mr.queue_lost%0d", k), {2'b0, PR_Write, PR_Exx, Busy}, 8'h00);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
